he_frame_sequencer: RTL
=======================

// Module: he_frame_sequencer
// PURPOSE
//  Sequences one histogram-equalisation pass over a frame held in a single-port frame SRAM.
//  Arbitrates the SRAM between host (load/readback) and the HE engine.
//  Job flow: stream NUM_PIXELS pixels SRAM->HE input, wait for HE output, write results back in place.
//  Sits between host bus, frame SRAM and HE core.
// PARAMETERS
//  NUM_PIXELS  290400  pixels per frame (660x440)
//  ADDR_W      19      SRAM/host address width; 2**ADDR_W >= NUM_PIXELS
//  DATA_W      8       pixel width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin job (honoured in IDLE/DONE only)
//  abort        in   1       synchronous abort: any state -> IDLE next cycle
//  busy         out  1       high from start accept until DONE entered
//  frame_done   out  1       1-cycle pulse on entry to DONE
//  err          out  1       sticky protocol error; cleared by start or reset
//  host_req     in   1       host access request
//  host_we      in   1       host write (1) / read (0)
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       combinational grant = host_req & (state in IDLE/DONE) & ~start
//  host_rdata   out  DATA_W  SRAM read data, valid 1 cycle after granted read
//  mem_en/mem_we out 1/1     SRAM enable / write enable
//  mem_addr     out  ADDR_W  SRAM address
//  mem_wdata    out  DATA_W  SRAM write data
//  mem_rdata    in   DATA_W  SRAM read data, 1-cycle latency
//  he_in_valid  out  1       pixel to HE valid
//  he_in_data   out  DATA_W  pixel to HE
//  he_in_ready  in   1       HE accepts pixel when valid&ready
//  he_out_valid in   1       transformed pixel from HE (no backpressure)
//  he_out_data  in   DATA_W  transformed pixel
// BEHAVIOUR
//  Reset: state IDLE; busy, frame_done, err, he_in_valid, mem_en, mem_we = 0; counters, buses = 0.
//  States: IDLE -start-> FEED -> WAIT -> WRITE -> DONE -start-> FEED; abort from any -> IDLE.
//  start and host_req same cycle: start wins, host_gnt=0.
//  FEED: rd_addr issues reads 0..NUM_PIXELS-1; data arrives next cycle; 2-entry skid FIFO
//   absorbs read latency so he_in_ready low stalls reads without loss; he_in_data stable while valid&~ready.
//   Throughput 1 pixel/cycle when ready held high; first he_in_valid 2 cycles after start.
//  FEED->WAIT when the NUM_PIXELS-th handshake completes; he_in_valid low in that next cycle.
//  he_out_valid seen in FEED or IDLE: set err, data dropped.
//  WAIT/WRITE: each he_out_valid writes mem_addr=wr_cnt, wr_cnt++; WAIT->WRITE on first;
//   WRITE->DONE after NUM_PIXELS-th write (no overflow: extras in DONE set err, not written).
//  SRAM port priority within job: write > read (never concurrent by construction).
//  Counters ADDR_W bits, compare to NUM_PIXELS-1; no wrap past frame end.
//  abort / reset mid-job: counters cleared, skid flushed, partially written frame left as-is.
// CONFIGURATION
//  HE_SEQ_PERF_EN defined: adds output perf_cycles[31:0] (cycles from start accept to DONE,
//   saturating at 2**32-1, held until next start) and perf_stalls[31:0] (cycles he_in_valid&~he_in_ready).
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package he_pkg: state enum (IDLE, FEED, WAIT, WRITE, DONE), NUM_PIXELS default, pixel typedef.
//  Sub-module he_skid_fifo (2-entry, valid/ready both sides) for the SRAM-read -> HE path.
//  Remaining arbitration/FSM/counters inline.
// TESTING
//  Host writes 16 pixels (NUM_PIXELS=16), start, HE ready always -> 16 in-handshakes in cycles 2..17, data in address order.
//  he_in_ready toggled 1/0 random in FEED -> no pixel lost/duplicated, he_in_data stable during stall.
//  HE model returns 255-x after WAIT -> SRAM addr k holds 255-orig[k]; frame_done pulse 1 cycle; host readback matches.
//  host_req with start same cycle -> host_gnt=0, job starts; host_req in FEED -> host_gnt stays 0.
//  he_out_valid during FEED -> err=1, SRAM unchanged; next start clears err.
//  abort at pixel 7 / reset_n low mid-WRITE -> IDLE, busy=0, next job completes correctly.

Source files
------------

// File: rtl/he_pkg.sv
// ---------------------------------------------------------------------------
// he_pkg
// Shared definitions for the histogram-equalisation frame sequencer.
//   he_state_t : sequencer FSM states (IDLE, FEED, WAIT, WRITE, DONE)
//   pixel_t    : default-width pixel
//   HE_*       : default frame geometry (660x440 frame, 8-bit pixels)
// ---------------------------------------------------------------------------
package he_pkg;

    localparam int unsigned HE_NUM_PIXELS = 290400;
    localparam int unsigned HE_ADDR_W     = 19;
    localparam int unsigned HE_DATA_W     = 8;

    typedef logic [HE_DATA_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } he_state_t;

endpackage

// File: rtl/he_skid_fifo.sv
// ---------------------------------------------------------------------------
// he_skid_fifo
// Two-entry FIFO with valid/ready on both sides, used to absorb the one-cycle
// SRAM read latency on the SRAM -> HE input path.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous clear of all entries (wins over push)
//   in_valid/in_data      : write side; in_ready low when both entries full
//   out_valid/out_data    : head of FIFO; head is stable until popped
//   out_ready             : consumer accepts head when out_valid & out_ready
//   level                 : number of occupied entries (0..2)
// ---------------------------------------------------------------------------
module he_skid_fifo #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] slot_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              push;
    logic              pop;

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = slot_reg[rd_ptr_reg];
    assign level     = count_reg;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg[gi] <= '0;
                end else if (!flush && push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/he_frame_sequencer.sv
// ---------------------------------------------------------------------------
// he_frame_sequencer
// Runs one histogram-equalisation pass over a frame held in a single-port
// SRAM: streams NUM_PIXELS pixels SRAM -> HE core, waits for the HE output,
// and writes the transformed pixels back in place. Between jobs the host
// owns the SRAM for loading and readback.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start, abort            : job start pulse (IDLE/DONE only), abort to IDLE
//   busy, frame_done, err   : job in progress, DONE-entry pulse, sticky error
//   host_req/we/addr/wdata  : host SRAM access; host_gnt combinational grant
//   host_rdata              : SRAM read data, one cycle after a granted read
//   mem_en/we/addr/wdata    : SRAM port; mem_rdata has one-cycle latency
//   he_in_valid/data/ready  : pixel stream to HE core
//   he_out_valid/data       : transformed pixels from HE core (no backpressure)
// Optional build macro HE_SEQ_PERF_EN adds perf_cycles / perf_stalls outputs.
// ---------------------------------------------------------------------------
module he_frame_sequencer
    import he_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = HE_NUM_PIXELS,
    parameter int unsigned ADDR_W     = HE_ADDR_W,
    parameter int unsigned DATA_W     = HE_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              frame_done,
    output logic              err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              he_in_valid,
    output logic [DATA_W-1:0] he_in_data,
    input  logic              he_in_ready,
    input  logic              he_out_valid,
    input  logic [DATA_W-1:0] he_out_data
`ifdef HE_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

    he_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] rd_cnt_reg, rd_cnt_next;
    logic [ADDR_W-1:0] in_cnt_reg, in_cnt_next;
    logic [ADDR_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic              rd_all_reg, rd_all_next;
    logic              inflight_reg, inflight_next;
    logic              err_reg, err_next;
    logic              frame_done_reg;

    logic              idle_like;
    logic              in_feed;
    logic              in_drain;
    logic              start_ok;
    logic              credit;
    logic              read_issue;
    logic              write_fire;
    logic [ADDR_W-1:0] issue_addr;

    logic              fifo_flush;
    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic              fifo_pop;
    logic [1:0]        fifo_level;

    assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
    assign in_feed   = (state_reg == FEED);
    assign in_drain  = (state_reg == WAIT) || (state_reg == WRITE);
    assign start_ok  = start & idle_like & ~abort;
    assign host_gnt  = host_req & idle_like & ~start;
    assign host_rdata = mem_rdata;

    assign busy       = in_feed || in_drain;
    assign frame_done = frame_done_reg;
    assign err        = err_reg;

    assign he_in_valid = fifo_out_valid & in_feed;
    assign fifo_pop    = he_in_valid & he_in_ready;
    assign fifo_flush  = abort | start_ok;

    // A read issued now lands in the FIFO next cycle, alongside any read
    // already in flight, so only issue when (level + in-flight - pop) < 2.
    // Full FIFO: only a pop makes room. One entry plus one in flight: the
    // pop is needed as well. Otherwise there is always room.
    assign credit = (fifo_in_ready | fifo_pop) &
                    ~((fifo_level == 2'd1) & inflight_reg & ~fifo_pop);

    he_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .in_valid  (inflight_reg),
        .in_data   (mem_rdata),
        .in_ready  (fifo_in_ready),
        .out_valid (fifo_out_valid),
        .out_data  (he_in_data),
        .out_ready (he_in_ready & in_feed),
        .level     (fifo_level)
    );

    always_comb begin
        state_next    = state_reg;
        rd_cnt_next   = rd_cnt_reg;
        in_cnt_next   = in_cnt_reg;
        wr_cnt_next   = wr_cnt_reg;
        rd_all_next   = rd_all_reg;
        inflight_next = 1'b0;
        err_next      = err_reg;
        issue_addr    = rd_cnt_reg;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        if (start_ok) begin
            rd_cnt_next = '0;
            in_cnt_next = '0;
            wr_cnt_next = '0;
            rd_all_next = 1'b0;
            issue_addr  = '0;
        end

        // Pixel 0 is read in the start cycle itself so the first pixel is
        // presented to the HE two cycles after start.
        read_issue = ~abort & (start_ok | (in_feed & ~rd_all_reg & credit));
        write_fire = ~abort & he_out_valid & in_drain;

        if (read_issue) begin
            inflight_next = 1'b1;
            if (issue_addr == LAST) rd_all_next = 1'b1;
            else                    rd_cnt_next = issue_addr + 1'b1;
        end
        if (fifo_pop && (in_cnt_reg != LAST)) in_cnt_next = in_cnt_reg + 1'b1;
        if (write_fire && (wr_cnt_reg != LAST)) wr_cnt_next = wr_cnt_reg + 1'b1;

        // HE output outside WAIT/WRITE is a protocol violation and is dropped.
        if (start_ok)                        err_next = 1'b0;
        else if (he_out_valid && !in_drain)  err_next = 1'b1;

        case (state_reg)
            IDLE, DONE: if (start_ok) state_next = FEED;
            FEED:       if (fifo_pop && (in_cnt_reg == LAST)) state_next = WAIT;
            WAIT:       if (he_out_valid) state_next = (wr_cnt_reg == LAST) ? DONE : WRITE;
            WRITE:      if (he_out_valid && (wr_cnt_reg == LAST)) state_next = DONE;
            default:    state_next = IDLE;
        endcase

        if (abort) begin
            state_next    = IDLE;
            rd_cnt_next   = '0;
            in_cnt_next   = '0;
            wr_cnt_next   = '0;
            rd_all_next   = 1'b0;
            inflight_next = 1'b0;
        end

        // Write-back and feed reads live in disjoint states; host only
        // outside a job. Priority order is kept anyway.
        if (write_fire) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_cnt_reg;
            mem_wdata = he_out_data;
        end else if (read_issue) begin
            mem_en   = 1'b1;
            mem_addr = issue_addr;
        end else if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            rd_cnt_reg     <= '0;
            in_cnt_reg     <= '0;
            wr_cnt_reg     <= '0;
            rd_all_reg     <= 1'b0;
            inflight_reg   <= 1'b0;
            err_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_cnt_reg     <= rd_cnt_next;
            in_cnt_reg     <= in_cnt_next;
            wr_cnt_reg     <= wr_cnt_next;
            rd_all_reg     <= rd_all_next;
            inflight_reg   <= inflight_next;
            err_reg        <= err_next;
            frame_done_reg <= (state_next == DONE) && (state_reg != DONE);
        end
    end

`ifdef HE_SEQ_PERF_EN
    logic [31:0] perf_cycles_reg;
    logic [31:0] perf_stalls_reg;

    assign perf_cycles = perf_cycles_reg;
    assign perf_stalls = perf_stalls_reg;

    // Both counters restart on start accept and hold after DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else if (start_ok) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else begin
            if (busy && (perf_cycles_reg != 32'hFFFF_FFFF))
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            if (he_in_valid && !he_in_ready && (perf_stalls_reg != 32'hFFFF_FFFF))
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
